bus_controller: RTL and testbench
=================================

Name: bus_controller

Overview:
- 68000-side bus glue that sits directly upstream of the DRAM controller.
- Decodes each CPU bus cycle into chip selects for DRAM, boot ROM and DUART, and drives the DRAM chip select that the DRAM controller consumes.
- Merges the per-device acknowledges into a single CPU DTACK, inserting programmable wait states for ROM.
- Also provides the reset-time ROM overlay at address 0, autovectored interrupt acknowledge (VPA) and a bus-error watchdog (BERR).

Parameters:
- ROM_WAIT, 2: CPU clocks from ROM chip select to DTACK (range 0-15).
- BERR_CYCLES, 64: CPU clocks from AS assertion with no termination to BERR assertion (range 2-255).
- BOOT_CYCLES, 8: completed bus cycles during which the ROM overlay is active after reset (range 1-15).

Ports:
- CLK  in  1  CPU clock; all logic on rising edge
- RST  in  1  synchronous reset, active-low
- AS  in  1  CPU address strobe, active-low
- UDS  in  1  upper data strobe, active-low
- LDS  in  1  lower data strobe, active-low
- RW  in  1  CPU read/write (1 = read)
- FC  in  3  CPU function code
- ADDR_IN  in  23  CPU address [23:1]
- DTACK_DRAM  in  1  acknowledge from DRAM controller, active-low
- DTACK_DUART  in  1  acknowledge from DUART, active-low
- CS_DRAM  out  1  DRAM chip select, active-low
- CS_ROM  out  1  ROM chip select, active-low
- CS_DUART  out  1  DUART chip select, active-low
- DTACK  out  1  CPU data acknowledge, active-low
- VPA  out  1  autovector request, active-low
- BERR  out  1  bus error, active-low
- BOOT  out  1  0 while ROM overlay is active

Behaviour:
- Reset (RST=0 at an edge): all CS, DTACK, VPA and BERR go to 1; BOOT=0; overlay counter=0; watchdog=0; state=IDLE.
- Inputs are synchronous to CLK; no synchronizers.
- Decode, applied to ADDR_IN<<1:
  - FC=3'b111: IACK.
  - BOOT=0 and A23=0: ROM.
  - A23=0: DRAM.
  - 0xF00000-0xF7FFFF: ROM.
  - 0xFF8000-0xFFBFFF: DUART.
  - Everything else: unmapped.
- State machine:
  - IDLE: AS=0 sampled → latch decode, clear watchdog, go to SELECT. The chosen CS (or VPA for IACK) goes low at this same edge, so latency from AS sample is 1 clock.
  - SELECT, ROM: a wait counter loads ROM_WAIT and decrements each clock; DTACK goes low on the edge after the counter reaches 0. With ROM_WAIT=0, DTACK follows CS by 1 clock.
  - SELECT, DRAM: DTACK is a registered copy of DTACK_DRAM (1 clock delay).
  - SELECT, DUART: DTACK is a registered copy of DTACK_DUART (1 clock delay).
  - SELECT, IACK: VPA stays low; DTACK stays high.
  - SELECT, unmapped: no CS and no acknowledge.
  - Once DTACK, VPA or BERR is asserted, it holds low until AS=1 is sampled.
  - Any state, AS=1 sampled → next edge all CS, DTACK, VPA and BERR go to 1, state=IDLE.
- Watchdog:
  - 8-bit counter increments each clock while in SELECT with DTACK, VPA and BERR all high.
  - On reaching BERR_CYCLES-1, BERR goes low the next edge and the watchdog saturates.
  - Chip selects are held until AS rises.
  - An acknowledge arriving on the same edge as the terminal count wins: DTACK asserts and BERR stays high.
- AS deasserted before the ROM wait counter expires → abort; return to IDLE; DTACK never asserts.
- Overlay counter:
  - Increments on each SELECT→IDLE transition while BOOT=0.
  - When a transition brings the count to BOOT_CYCLES, BOOT becomes 1 on that edge and remains 1 until reset.
  - Aborted and bus-errored cycles count.
- Back-to-back cycles: a minimum of one IDLE clock between cycles; AS=0 sampled in that IDLE clock starts the next cycle.
- UDS, LDS and RW do not affect decode. They are ports for byte-strobe gating of ROM and DUART chip selects: CS_ROM and CS_DUART assert only when UDS=0 or LDS=0. CS_DRAM is not gated, because the DRAM controller uses the strobes itself.
- Reset mid-cycle: all outputs return to reset values on that edge and the overlay is reinstated.

Decomposition:
- Shared package holds:
  - Memory map base and mask constants (DRAM, ROM, DUART, overlay window).
  - Device select enum (NONE, DRAM, ROM, DUART, IACK).
  - State encoding (IDLE, SELECT).
- One natural sub-module, bus_watchdog: counter, saturation and BERR output, with an enable/clear interface.
- Decode is a pure function kept in the package.

Test Plan:
- After reset, 8 reads at 0x000000 → CS_ROM low, CS_DRAM high, BOOT=0. 9th read at 0x000000 → CS_DRAM low, BOOT=1.
- ROM read at 0xF00010 with ROM_WAIT=2 → CS_ROM low 1 clock after AS sampled, DTACK low 3 clocks after CS. AS high → all outputs high next edge.
- DRAM read at 0x001000 with BOOT=1, DTACK_DRAM driven low 4 clocks later → DTACK low exactly 1 clock after DTACK_DRAM.
- Unmapped write at 0xE00000 → no CS; BERR low at clock BERR_CYCLES after SELECT entry; held until AS high.
- FC=7 IACK cycle → VPA low 1 clock after AS sampled, DTACK stays high. Separately, DTACK_DUART arriving on the watchdog terminal clock → DTACK low, BERR stays high.
- RST low mid-ROM-wait after BOOT=1 → all outputs high, BOOT=0 on that edge. Also: AS rising before the ROM wait expires → DTACK never asserts.

Source files
------------

// File: rtl/bus_controller_pkg.sv
// Shared memory map, device/state encodings and the address decode used by the
// 68000 bus glue.
package bus_controller_pkg;

  localparam logic [23:0] DRAM_BASE  = 24'h000000;
  localparam logic [23:0] DRAM_MASK  = 24'h800000;
  localparam logic [23:0] OVL_BASE   = 24'h000000;
  localparam logic [23:0] OVL_MASK   = 24'h800000;
  localparam logic [23:0] ROM_BASE   = 24'hF00000;
  localparam logic [23:0] ROM_MASK   = 24'hF80000;
  localparam logic [23:0] DUART_BASE = 24'hFF8000;
  localparam logic [23:0] DUART_MASK = 24'hFFC000;
  localparam logic [2:0]  FC_IACK    = 3'b111;

  typedef enum logic [2:0] {
    DEV_NONE,
    DEV_DRAM,
    DEV_ROM,
    DEV_DUART,
    DEV_IACK
  } dev_t;

  typedef enum logic {
    ST_IDLE,
    ST_SELECT
  } state_t;

  // boot_active is high while the reset-time ROM overlay shadows low memory.
  function automatic dev_t decode(input logic [2:0] fc, input logic [22:0] addr,
                                  input logic boot_active);
    logic [23:0] a;
    dev_t        dev;
    a = {addr, 1'b0};
    if (fc == FC_IACK)
      dev = DEV_IACK;
    else if (boot_active && ((a & OVL_MASK) == OVL_BASE))
      dev = DEV_ROM;
    else if ((a & DRAM_MASK) == DRAM_BASE)
      dev = DEV_DRAM;
    else if ((a & ROM_MASK) == ROM_BASE)
      dev = DEV_ROM;
    else if ((a & DUART_MASK) == DUART_BASE)
      dev = DEV_DUART;
    else
      dev = DEV_NONE;
    return dev;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus-error watchdog: counts unterminated SELECT clocks and raises BERR
// (active-low) once the terminal count is reached, then saturates.
module bus_watchdog #(
  parameter int BERR_CYCLES = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  input  logic en_i,
  output logic berr_o
);

  logic [7:0] cnt_q;
  logic       berr_q;

  always_ff @(posedge CLK) begin
    if (!RST || clr_i) begin
      cnt_q  <= 8'd0;
      berr_q <= 1'b1;
    end else if (en_i && berr_q) begin
      if (cnt_q == 8'(BERR_CYCLES - 1))
        berr_q <= 1'b0;
      else
        cnt_q <= cnt_q + 8'd1;
    end
  end

  assign berr_o = berr_q;

endmodule

// File: rtl/bus_controller.sv
// 68000 bus glue: chip-select decode, DTACK merge with ROM wait states,
// boot-time ROM overlay, autovectored IACK and bus-error watchdog.
module bus_controller
  import bus_controller_pkg::*;
#(
  parameter int ROM_WAIT    = 2,
  parameter int BERR_CYCLES = 64,
  parameter int BOOT_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW,
  input  logic [2:0]  FC,
  input  logic [22:0] ADDR_IN,
  input  logic        DTACK_DRAM,
  input  logic        DTACK_DUART,
  output logic        CS_DRAM,
  output logic        CS_ROM,
  output logic        CS_DUART,
  output logic        DTACK,
  output logic        VPA,
  output logic        BERR,
  output logic        BOOT
);

  state_t     state_q;
  dev_t       dev_q;
  logic [3:0] wait_q;
  logic [3:0] boot_cnt_q;
  logic       boot_q;
  logic       cs_dram_q, cs_rom_q, cs_duart_q;
  logic       dtack_q, vpa_q;

  dev_t dev_dec;
  logic strobe;
  logic dtack_d;
  logic berr;
  logic unused_rw;

  assign dev_dec   = decode(FC, ADDR_IN, !boot_q);
  assign strobe    = !UDS || !LDS;
  assign unused_rw = RW;

  // Next DTACK while the cycle is still running; a bus error freezes it high.
  always_comb begin
    dtack_d = dtack_q;
    if (berr) begin
      case (dev_q)
        DEV_DRAM:  dtack_d = dtack_q & DTACK_DRAM;
        DEV_DUART: dtack_d = dtack_q & DTACK_DUART;
        DEV_ROM:   if (wait_q == 4'd0) dtack_d = 1'b0;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      dev_q      <= DEV_NONE;
      wait_q     <= 4'd0;
      boot_cnt_q <= 4'd0;
      boot_q     <= 1'b0;
      cs_dram_q  <= 1'b1;
      cs_rom_q   <= 1'b1;
      cs_duart_q <= 1'b1;
      dtack_q    <= 1'b1;
      vpa_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!AS) begin
            state_q    <= ST_SELECT;
            dev_q      <= dev_dec;
            wait_q     <= 4'(ROM_WAIT);
            cs_dram_q  <= !(dev_dec == DEV_DRAM);
            cs_rom_q   <= !(dev_dec == DEV_ROM && strobe);
            cs_duart_q <= !(dev_dec == DEV_DUART && strobe);
            vpa_q      <= !(dev_dec == DEV_IACK);
          end
        end
        ST_SELECT: begin
          if (AS) begin
            state_q    <= ST_IDLE;
            cs_dram_q  <= 1'b1;
            cs_rom_q   <= 1'b1;
            cs_duart_q <= 1'b1;
            dtack_q    <= 1'b1;
            vpa_q      <= 1'b1;
            // Every finished cycle, aborted or errored, ages the overlay.
            if (!boot_q) begin
              boot_cnt_q <= boot_cnt_q + 4'd1;
              if (boot_cnt_q == 4'(BOOT_CYCLES - 1))
                boot_q <= 1'b1;
            end
          end else begin
            cs_rom_q   <= !(dev_q == DEV_ROM && strobe);
            cs_duart_q <= !(dev_q == DEV_DUART && strobe);
            dtack_q    <= dtack_d;
            if (dev_q == DEV_ROM && wait_q != 4'd0)
              wait_q <= wait_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Counting stops as soon as any termination is present or about to be.
  bus_watchdog #(
    .BERR_CYCLES(BERR_CYCLES)
  ) u_watchdog (
    .CLK    (CLK),
    .RST    (RST),
    .clr_i  ((state_q != ST_SELECT) || AS),
    .en_i   (dtack_q && vpa_q && dtack_d),
    .berr_o (berr)
  );

  assign CS_DRAM  = cs_dram_q;
  assign CS_ROM   = cs_rom_q;
  assign CS_DUART = cs_duart_q;
  assign DTACK    = dtack_q;
  assign VPA      = vpa_q;
  assign BERR     = berr;
  assign BOOT     = boot_q;

endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller: decode table, directed multi-cycle
// sequences and randomized bus cycles checked against a cycle-timing model.
module tb_bus_controller;

  localparam int ROM_WAIT    = 2;
  localparam int BERR_CYCLES = 64;
  localparam int BOOT_CYCLES = 8;
  localparam int NEVER       = 1000000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        AS = 1'b1, UDS = 1'b1, LDS = 1'b1, RW = 1'b1;
  logic [2:0]  FC = 3'd0;
  logic [22:0] ADDR_IN = 23'd0;
  logic        DTACK_DRAM = 1'b1, DTACK_DUART = 1'b1;
  logic        CS_DRAM, CS_ROM, CS_DUART, DTACK, VPA, BERR, BOOT;
  logic [6:0]  outs;

  int checks = 0;
  int errors = 0;
  int done_cycles = 0;

  typedef enum int {M_NONE, M_DRAM, M_ROM, M_DUART, M_IACK} mdev_t;

  typedef struct packed {
    logic [2:0]  fc;
    logic [23:0] byte_addr;
    logic        uds;
    logic        lds;
    logic [2:0]  exp_cs;   // {CS_DRAM, CS_ROM, CS_DUART}
    logic        exp_vpa;
  } vec_t;

  bus_controller #(
    .ROM_WAIT(ROM_WAIT), .BERR_CYCLES(BERR_CYCLES), .BOOT_CYCLES(BOOT_CYCLES)
  ) dut (
    .CLK(CLK), .RST(RST), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .FC(FC),
    .ADDR_IN(ADDR_IN), .DTACK_DRAM(DTACK_DRAM), .DTACK_DUART(DTACK_DUART),
    .CS_DRAM(CS_DRAM), .CS_ROM(CS_ROM), .CS_DUART(CS_DUART), .DTACK(DTACK),
    .VPA(VPA), .BERR(BERR), .BOOT(BOOT)
  );

  assign outs = {CS_DRAM, CS_ROM, CS_DUART, DTACK, VPA, BERR, BOOT};

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int txn, input int clk,
                       input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s txn %0d clk %0d: got %b want %b", name, txn, clk, got, want);
    end
  endtask

  // Memory map written as plain byte-address ranges.
  function automatic mdev_t model_decode(input logic [2:0] fc, input int byte_addr,
                                         input bit overlay);
    if (fc == 3'd7) return M_IACK;
    if (byte_addr < 'h800000) return overlay ? M_ROM : M_DRAM;
    if (byte_addr >= 'hF00000 && byte_addr <= 'hF7FFFF) return M_ROM;
    if (byte_addr >= 'hFF8000 && byte_addr <= 'hFFBFFF) return M_DUART;
    return M_NONE;
  endfunction

  // One bus cycle: AS held low for 'hold' edges (E0 = select edge), device ack
  // line low from edge 'ack_at' on, then AS released; every clock is checked.
  task automatic run_txn(input int txn, input logic [2:0] fc, input int byte_addr,
                         input logic uds, input logic lds, input logic rw,
                         input int hold, input int ack_at, input string tag);
    mdev_t       dev;
    bit          overlay, strobe, acked;
    int          t_ack;
    logic        lvl;
    logic [23:0] ba;
    logic [6:0]  want;
    overlay = done_cycles < BOOT_CYCLES;
    dev     = model_decode(fc, byte_addr, overlay);
    strobe  = !uds || !lds;
    case (dev)
      M_DRAM, M_DUART: t_ack = ack_at;
      M_ROM:           t_ack = ROM_WAIT + 1;
      default:         t_ack = NEVER;
    endcase
    acked = t_ack <= BERR_CYCLES;
    ba = 24'(byte_addr);
    FC = fc; ADDR_IN = ba[23:1]; UDS = uds; LDS = lds; RW = rw; AS = 1'b0;
    for (int j = 0; j < hold; j++) begin
      lvl = (j >= ack_at) ? 1'b0 : 1'b1;
      DTACK_DRAM  = (dev == M_DUART) ? 1'b1 : lvl;
      DTACK_DUART = (dev == M_DRAM)  ? 1'b1 : lvl;
      tick;
      want = {dev != M_DRAM,
              !(dev == M_ROM && strobe),
              !(dev == M_DUART && strobe),
              !(acked && j >= t_ack),
              dev != M_IACK,
              !(!acked && dev != M_IACK && j >= BERR_CYCLES),
              !overlay};
      check(tag, txn, j, outs, want);
    end
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1; DTACK_DRAM = 1'b1; DTACK_DUART = 1'b1;
    tick;
    done_cycles++;
    check({tag, "_end"}, txn, hold, outs, {6'h3F, done_cycles >= BOOT_CYCLES});
    $display("txn %0d %s fc=%0d addr=%06h dev=%s hold=%0d ack_at=%0d", txn, tag, fc,
             ba, dev.name(), hold, ack_at);
  endtask

  vec_t vecs [14];

  initial begin
    logic [23:0] ba;
    int          sel, addr, hold, ack_at;
    logic [2:0]  fc;
    logic [1:0]  st;

    vecs[0]  = '{3'd5, 24'h000000, 1'b0, 1'b0, 3'b011, 1'b1};
    vecs[1]  = '{3'd5, 24'h7FFFFE, 1'b1, 1'b1, 3'b011, 1'b1};
    vecs[2]  = '{3'd5, 24'h800000, 1'b0, 1'b0, 3'b111, 1'b1};
    vecs[3]  = '{3'd6, 24'hF00000, 1'b0, 1'b0, 3'b101, 1'b1};
    vecs[4]  = '{3'd6, 24'hF7FFFE, 1'b1, 1'b0, 3'b101, 1'b1};
    vecs[5]  = '{3'd6, 24'hF80000, 1'b0, 1'b0, 3'b111, 1'b1};
    vecs[6]  = '{3'd5, 24'hFF7FFE, 1'b0, 1'b0, 3'b111, 1'b1};
    vecs[7]  = '{3'd5, 24'hFF8000, 1'b0, 1'b1, 3'b110, 1'b1};
    vecs[8]  = '{3'd5, 24'hFFBFFE, 1'b0, 1'b0, 3'b110, 1'b1};
    vecs[9]  = '{3'd5, 24'hFFC000, 1'b0, 1'b0, 3'b111, 1'b1};
    vecs[10] = '{3'd6, 24'hF00000, 1'b1, 1'b1, 3'b111, 1'b1};
    vecs[11] = '{3'd5, 24'hFF8000, 1'b1, 1'b1, 3'b111, 1'b1};
    vecs[12] = '{3'd7, 24'hFFFFF6, 1'b0, 1'b0, 3'b111, 1'b0};
    vecs[13] = '{3'd7, 24'h000000, 1'b0, 1'b0, 3'b111, 1'b0};

    // Reset state.
    RST = 1'b0;
    tick;
    tick;
    check("reset", 0, 0, outs, 7'b1111110);
    RST = 1'b1;
    tick;
    check("reset_idle", 0, 1, outs, 7'b1111110);

    // Overlay: eight ROM reads at 0, the ninth goes to DRAM.
    for (int i = 0; i < BOOT_CYCLES; i++)
      run_txn(i, 3'd6, 'h000000, 1'b0, 1'b0, 1'b1, 5, 1, "boot");
    run_txn(BOOT_CYCLES, 3'd6, 'h000000, 1'b0, 1'b0, 1'b1, 5, 2, "boot_done");

    // Decode table, one select clock each.
    for (int i = 0; i < 14; i++) begin
      ba = vecs[i].byte_addr;
      FC = vecs[i].fc; ADDR_IN = ba[23:1]; UDS = vecs[i].uds; LDS = vecs[i].lds;
      AS = 1'b0;
      tick;
      check("tbl", 50 + i, 0, {3'b000, CS_DRAM, CS_ROM, CS_DUART, VPA},
            {3'b000, vecs[i].exp_cs, vecs[i].exp_vpa});
      AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
      tick;
      done_cycles++;
      check("tbl_end", 50 + i, 1, outs, 7'b1111111);
      $display("txn %0d tbl fc=%0d addr=%06h", 50 + i, vecs[i].fc, ba);
    end

    // Directed multi-cycle sequences.
    run_txn(100, 3'd6, 'hF00010, 1'b0, 1'b0, 1'b1, 6, 1, "rom_wait");
    run_txn(101, 3'd5, 'h001000, 1'b0, 1'b0, 1'b1, 7, 4, "dram");
    run_txn(102, 3'd5, 'hE00000, 1'b1, 1'b0, 1'b0, 70, NEVER, "unmapped");
    run_txn(103, 3'd7, 'hFFFFF4, 1'b0, 1'b0, 1'b1, 5, 1, "iack");
    run_txn(104, 3'd5, 'hFF8000, 1'b1, 1'b0, 1'b0, 68, BERR_CYCLES, "duart_race");
    run_txn(105, 3'd5, 'hFF8002, 1'b0, 1'b0, 1'b1, 68, BERR_CYCLES + 1, "duart_late");

    // Reset in the middle of a ROM wait.
    ba = 24'hF00010;
    FC = 3'd6; ADDR_IN = ba[23:1]; UDS = 1'b0; LDS = 1'b0; AS = 1'b0;
    tick;
    check("rst_mid_sel", 200, 0, outs, 7'b1011111);
    tick;
    check("rst_mid_wait", 200, 1, outs, 7'b1011111);
    RST = 1'b0;
    tick;
    check("rst_mid", 200, 2, outs, 7'b1111110);
    RST = 1'b1; AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    done_cycles = 0;
    tick;
    check("rst_mid_idle", 200, 3, outs, 7'b1111110);
    $display("txn 200 rst_mid_rom_wait");

    // Aborts before the ROM wait expires (overlay active again).
    run_txn(201, 3'd6, 'h000100, 1'b0, 1'b0, 1'b1, 3, 1, "abort3");
    run_txn(202, 3'd6, 'hF00020, 1'b0, 1'b0, 1'b1, 1, 1, "abort1");

    // Randomized cycles; the first few still see the overlay.
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 4));
      fc  = 3'($urandom_range(0, 6));
      case (sel)
        0: addr = int'($urandom_range(0, 'h7FFFFF));
        1: addr = 'hF00000 + int'($urandom_range(0, 'h7FFFF));
        2: addr = 'hFF8000 + int'($urandom_range(0, 'h3FFF));
        3: addr = int'($urandom_range(0, 'hFFFFFF));
        default: begin
          addr = int'($urandom_range(0, 'hFFFFFF));
          fc   = 3'd7;
        end
      endcase
      if ($urandom_range(0, 7) == 0) hold = BERR_CYCLES + int'($urandom_range(0, 4));
      else hold = int'($urandom_range(1, 10));
      if ($urandom_range(0, 9) == 0) ack_at = BERR_CYCLES - 1 + int'($urandom_range(0, 2));
      else ack_at = int'($urandom_range(1, 8));
      st = 2'($urandom_range(0, 3));
      run_txn(300 + t, fc, addr, st[1], st[0], 1'($urandom_range(0, 1)), hold, ack_at,
              "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
